// File: rtl/wb_scoreboard_pkg.sv
// wb_scoreboard_pkg: shared sizes and types for the register write-back scoreboard
package wb_scoreboard_pkg;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 4;
  localparam int CNT_W = 2;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] pend_cnt_t;
  localparam pend_cnt_t CNT_MAX = '1;
endpackage

// File: rtl/wb_scoreboard_cell.sv
// sb_cell: saturating pending-write counter for one architectural register
module sb_cell
  import wb_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_inc,
  input  logic      i_dec,
  output pend_cnt_t o_cnt,
  output logic      o_nonzero,
  output logic      o_ovf_pulse,
  output logic      o_udf_pulse
);
  pend_cnt_t r_cnt;
  logic      r_nz;
  pend_cnt_t w_nxt;
  always_comb begin
    o_ovf_pulse = i_inc & ~i_dec & (r_cnt == CNT_MAX);
    o_udf_pulse = ~i_inc & i_dec & (r_cnt == '0);
    w_nxt = (i_inc & ~i_dec & ~o_ovf_pulse) ? r_cnt + 1'b1 :
            (~i_inc & i_dec & ~o_udf_pulse) ? r_cnt - 1'b1 : r_cnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt <= '0;
      r_nz  <= 1'b0;
    end else begin
      r_cnt <= w_nxt;
      r_nz  <= |w_nxt;
    end
  assign o_cnt = r_cnt;
  assign o_nonzero = r_nz;
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending counters between ID issue and WB write-back,
// with same-cycle write-back bypass into the ID hazard check
module wb_scoreboard
  import wb_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_wb_en,
  input  reg_idx_t            issue_dest,
  input  reg_idx_t            src1,
  input  logic                src1_used,
  input  reg_idx_t            src2,
  input  logic                two_src,
  input  logic                writeBackEn,
  input  reg_idx_t            Dest_wb,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending,
  output logic                idle,
  output logic                err_overflow,
  output logic                err_underflow
);
  pend_cnt_t           w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_hit, w_inc, w_busy, w_ovf, w_udf;
  logic                w_accept;
  logic                r_err_ovf, r_err_udf;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    pend_cnt_t w_eff;
    assign w_hit[g] = writeBackEn & (Dest_wb == reg_idx_t'(g));
    assign w_inc[g] = w_accept & (issue_dest == reg_idx_t'(g));
    assign w_eff = w_cnt[g] - pend_cnt_t'(w_hit[g]);
    assign w_busy[g] = |w_eff;
    sb_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_inc[g]),
      .i_dec      (w_hit[g]),
      .o_cnt      (w_cnt[g]),
      .o_nonzero  (pending[g]),
      .o_ovf_pulse(w_ovf[g]),
      .o_udf_pulse(w_udf[g])
    );
  end
  assign hazard = (src1_used & w_busy[src1]) | (two_src & w_busy[src2]);
  assign w_accept = issue_valid & issue_wb_en & ~hazard;
  assign idle = ~|pending;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_err_ovf <= r_err_ovf | (|w_ovf);
      r_err_udf <= r_err_udf | (|w_udf);
    end
  assign err_overflow = r_err_ovf;
  assign err_underflow = r_err_udf;
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: scoreboard bench with an independent counter model of the pending table
module tb_wb_scoreboard;
  logic clk = 0, rst = 1;
  logic issue_valid = 0, issue_wb_en = 0, src1_used = 0, two_src = 0, writeBackEn = 0;
  logic [3:0] issue_dest = 0, src1 = 0, src2 = 0, Dest_wb = 0;
  logic hazard, idle, err_overflow, err_underflow;
  logic [15:0] pending;
  int n_tests = 0, n_fail = 0;
  typedef struct { logic [15:0] pend; logic idl, eo, eu; } exp_t;
  exp_t q[$];
  int m_cnt[16];
  bit m_eo, m_eu;

  wb_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .src1(src1), .src1_used(src1_used), .src2(src2),
    .two_src(two_src), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .hazard(hazard),
    .pending(pending), .idle(idle), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy(int r, bit wb, int dwb);
    int e;
    e = (m_cnt[r] - ((wb && dwb == r) ? 1 : 0) + 4) % 4;
    return e != 0;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_eo = 0;
    m_eu = 0;
  endtask

  task automatic step(input string tag, input bit iv, input bit wen, input int dest,
                      input int s1, input bit u1, input int s2, input bit t2,
                      input bit wb, input int dwb);
    bit haz, acc, inc, hit;
    exp_t e;
    issue_valid = iv; issue_wb_en = wen; issue_dest = 4'(dest);
    src1 = 4'(s1); src1_used = u1; src2 = 4'(s2); two_src = t2;
    writeBackEn = wb; Dest_wb = 4'(dwb);
    haz = (u1 && m_busy(s1, wb, dwb)) || (t2 && m_busy(s2, wb, dwb));
    acc = iv && wen && !haz;
    for (int r = 0; r < 16; r++) begin
      inc = acc && dest == r;
      hit = wb && dwb == r;
      if (inc && !hit) begin
        if (m_cnt[r] == 3) m_eo = 1; else m_cnt[r]++;
      end else if (hit && !inc) begin
        if (m_cnt[r] == 0) m_eu = 1; else m_cnt[r]--;
      end
    end
    e.pend = '0;
    for (int r = 0; r < 16; r++) e.pend[r] = m_cnt[r] != 0;
    e.idl = e.pend == 0;
    e.eo = m_eo;
    e.eu = m_eu;
    q.push_back(e);
    #1;
    check({tag, ".hazard"}, 32'(hazard), 32'(haz));
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".pending"}, 32'(pending), 32'(e.pend));
    check({tag, ".idle"}, 32'(idle), 32'(e.idl));
    check({tag, ".err_ovf"}, 32'(err_overflow), 32'(e.eo));
    check({tag, ".err_udf"}, 32'(err_underflow), 32'(e.eu));
  endtask

  task automatic idle_step(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    src1 = 4'd3; src1_used = 1;
    #1;
    check("rst.hazard", 32'(hazard), 0);
    check("rst.pending", 32'(pending), 0);
    check("rst.idle", 32'(idle), 1);
    check("rst.errs", {err_overflow, err_underflow}, 0);
    @(posedge clk);
    #1 rst = 0;
    step("iss3", 1, 1, 3, 0, 0, 0, 0, 0, 0);
    step("haz3", 0, 0, 0, 3, 1, 0, 0, 0, 0);
    step("wb3", 0, 0, 0, 3, 1, 0, 0, 1, 3);
    step("iss5a", 1, 1, 5, 0, 0, 0, 0, 0, 0);
    step("iss5b", 1, 1, 5, 0, 0, 0, 0, 0, 0);
    step("wb5a", 0, 0, 0, 5, 1, 0, 0, 1, 5);
    step("wb5b", 0, 0, 0, 5, 1, 0, 0, 1, 5);
    step("iss7", 1, 1, 7, 0, 0, 0, 0, 0, 0);
    step("isswb7", 1, 1, 7, 0, 0, 0, 0, 1, 7);
    step("nosrc2", 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step("src2_7", 0, 0, 0, 0, 1, 7, 1, 0, 0);
    step("wb7", 0, 0, 0, 0, 0, 0, 0, 1, 7);
    for (int k = 0; k < 4; k++) step("ovf2", 1, 1, 2, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("drain2", 0, 0, 0, 2, 1, 0, 0, 1, 2);
    step("udf9", 0, 0, 0, 0, 0, 0, 0, 1, 9);
    step("iss1", 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step("blocked", 1, 1, 1, 1, 1, 0, 0, 0, 0);
    step("blocked2", 1, 1, 6, 0, 0, 1, 1, 0, 0);
    step("wb1", 0, 0, 0, 1, 1, 0, 0, 1, 1);
    for (int k = 0; k < 40; k++)
      step("rand", $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 15));
    step("iss4a", 1, 1, 4, 0, 0, 0, 0, 0, 0);
    step("iss4b", 1, 1, 4, 0, 0, 0, 0, 0, 0);
    issue_valid = 0; writeBackEn = 0; src1 = 4'd4; src1_used = 1; two_src = 0;
    #2 rst = 1;
    model_reset();
    #1;
    check("arst.hazard", 32'(hazard), 0);
    check("arst.pending", 32'(pending), 0);
    check("arst.idle", 32'(idle), 1);
    check("arst.errs", {err_overflow, err_underflow}, 0);
    @(posedge clk);
    #1 rst = 0;
    step("post_rst", 0, 0, 0, 4, 1, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
